// File: rtl/mi_arbiter.sv
// mi_arbiter: round-robin share of the single QSPI memory interface between
// N_REQ requesters. One transaction is in flight at a time, and the grant is
// held from command acceptance until the controller signals the last beat.
module mi_arbiter #(
    parameter int N_REQ = 2,
    parameter int AW    = 24,
    parameter int LW    = 7
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ*AW-1:0] u_addr,
    input  logic [N_REQ*LW-1:0] u_len,
    input  logic [N_REQ-1:0]    u_rw,
    input  logic [N_REQ-1:0]    u_valid,
    output logic [N_REQ-1:0]    u_ready,
    input  logic [N_REQ*32-1:0] u_wdata,
    output logic [N_REQ-1:0]    u_wack,
    output logic [N_REQ-1:0]    u_wlast,
    output logic [31:0]         u_rdata,
    output logic [N_REQ-1:0]    u_rstb,
    output logic [N_REQ-1:0]    u_rlast,
    output logic [AW-1:0]       mi_addr,
    output logic [LW-1:0]       mi_len,
    output logic                mi_rw,
    output logic                mi_valid,
    input  logic                mi_ready,
    output logic [31:0]         mi_wdata,
    input  logic                mi_wack,
    input  logic                mi_wlast,
    input  logic [31:0]         mi_rdata,
    input  logic                mi_rstb,
    input  logic                mi_rlast
);

    localparam int GW = (N_REQ > 2) ? 2 : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [GW-1:0]   lastGrant_q, lastGrant_d;
    logic            curRw_q, curRw_d;

    logic [GW-1:0]   rrPick;
    logic            rrFound;

    logic [AW-1:0]   addrArr  [N_REQ];
    logic [LW-1:0]   lenArr   [N_REQ];
    logic [31:0]     wdataArr [N_REQ];

    // Slice the flattened requester buses into per-requester arrays.
    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign addrArr[g]  = u_addr[g*AW +: AW];
        assign lenArr[g]   = u_len[g*LW +: LW];
        assign wdataArr[g] = u_wdata[g*32 +: 32];
    end

    // Read data is broadcast; only the strobes say who it belongs to.
    assign u_rdata = mi_rdata;

    // Round-robin search starting just after the last requester served.
    always_comb begin
        int idx;
        rrPick  = '0;
        rrFound = 1'b0;
        idx     = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(lastGrant_q) + k) % N_REQ;
            if (!rrFound && u_valid[GW'(idx)]) begin
                rrPick  = GW'(idx);
                rrFound = 1'b1;
            end
        end
    end

    // State register; reset makes requester 0 the first winner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            lastGrant_q <= GW'(N_REQ - 1);
            curRw_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            lastGrant_q <= lastGrant_d;
            curRw_q     <= curRw_d;
        end
    end

    // Next-state logic and the granted-port steering of all handshakes.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        lastGrant_d = lastGrant_q;
        curRw_d     = curRw_q;

        mi_addr  = addrArr[grant_q];
        mi_len   = lenArr[grant_q];
        mi_rw    = u_rw[grant_q];
        mi_wdata = wdataArr[grant_q];
        mi_valid = 1'b0;
        u_ready  = '0;
        u_rstb   = '0;
        u_rlast  = '0;
        u_wack   = '0;
        u_wlast  = '0;

        case (state_q)
            IDLE: begin
                if (rrFound) begin
                    grant_d = rrPick;
                    state_d = CMD;
                end
            end
            CMD: begin
                mi_valid         = u_valid[grant_q];
                u_ready[grant_q] = mi_ready;
                if (u_valid[grant_q] && mi_ready) begin
                    lastGrant_d = grant_q;
                    curRw_d     = u_rw[grant_q];
                    state_d     = DATA;
                end else if (!u_valid[grant_q]) begin
                    state_d = IDLE;
                end
            end
            DATA: begin
                if (curRw_q) begin
                    u_rstb[grant_q]  = mi_rstb;
                    u_rlast[grant_q] = mi_rlast;
                    if (mi_rstb && mi_rlast) begin
                        state_d = IDLE;
                    end
                end else begin
                    u_wack[grant_q]  = mi_wack;
                    u_wlast[grant_q] = mi_wlast;
                    if (mi_wack && mi_wlast) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mi_arbiter.sv
// tb_mi_arbiter: randomized requesters and a randomized controller driven
// against a transaction-level round-robin model of the arbiter.
module tb_mi_arbiter;

    localparam int N_REQ = 2;
    localparam int AW    = 24;
    localparam int LW    = 7;

    logic                clk = 1'b0;
    logic                rst;
    logic [N_REQ*AW-1:0] u_addr;
    logic [N_REQ*LW-1:0] u_len;
    logic [N_REQ-1:0]    u_rw;
    logic [N_REQ-1:0]    u_valid;
    logic [N_REQ-1:0]    u_ready;
    logic [N_REQ*32-1:0] u_wdata;
    logic [N_REQ-1:0]    u_wack;
    logic [N_REQ-1:0]    u_wlast;
    logic [31:0]         u_rdata;
    logic [N_REQ-1:0]    u_rstb;
    logic [N_REQ-1:0]    u_rlast;
    logic [AW-1:0]       mi_addr;
    logic [LW-1:0]       mi_len;
    logic                mi_rw;
    logic                mi_valid;
    logic                mi_ready;
    logic [31:0]         mi_wdata;
    logic                mi_wack;
    logic                mi_wlast;
    logic [31:0]         mi_rdata;
    logic                mi_rstb;
    logic                mi_rlast;

    always #5 clk = ~clk;

    mi_arbiter #(.N_REQ(N_REQ), .AW(AW), .LW(LW)) dut (
        .clk(clk), .rst(rst),
        .u_addr(u_addr), .u_len(u_len), .u_rw(u_rw), .u_valid(u_valid),
        .u_ready(u_ready), .u_wdata(u_wdata), .u_wack(u_wack), .u_wlast(u_wlast),
        .u_rdata(u_rdata), .u_rstb(u_rstb), .u_rlast(u_rlast),
        .mi_addr(mi_addr), .mi_len(mi_len), .mi_rw(mi_rw), .mi_valid(mi_valid),
        .mi_ready(mi_ready), .mi_wdata(mi_wdata), .mi_wack(mi_wack),
        .mi_wlast(mi_wlast), .mi_rdata(mi_rdata), .mi_rstb(mi_rstb),
        .mi_rlast(mi_rlast)
    );

    int checks = 0;
    int errors = 0;

    // Requester-side view of each pending command.
    logic           reqValid [N_REQ];
    logic [AW-1:0]  reqAddr  [N_REQ];
    logic [LW-1:0]  reqLen   [N_REQ];
    logic           reqRw    [N_REQ];
    logic [31:0]    reqWdata [N_REQ];

    // Transaction-level view of the shared bus.
    typedef enum {P_FREE, P_CMD, P_DATA} phase_t;
    phase_t phase;
    int     winner;
    int     lastWin;
    int     beatsLeft;
    logic   busRw;
    int     txnDone;
    int     grantLog [$];

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic int rrWinner();
        for (int k = 1; k <= N_REQ; k++) begin
            int idx;
            idx = (lastWin + k) % N_REQ;
            if (reqValid[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic newCommand(input int i);
        reqValid[i] = 1'b1;
        reqAddr[i]  = AW'($urandom);
        reqLen[i]   = LW'($urandom_range(5));
        reqRw[i]    = 1'($urandom_range(1));
    endtask

    task automatic driveBus();
        for (int i = 0; i < N_REQ; i++) begin
            u_valid[i]           = reqValid[i];
            u_addr[i*AW +: AW]   = reqAddr[i];
            u_len[i*LW +: LW]    = reqLen[i];
            u_rw[i]              = reqRw[i];
            u_wdata[i*32 +: 32]  = reqWdata[i];
        end
    endtask

    // One cycle: drive just after negedge, check at +1, advance the model.
    task automatic applyStimulus(input bit allowNew);
        bit beat;
        int w;
        logic [N_REQ-1:0] expReady, expRstb, expRlast, expWack, expWlast;
        beat = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!reqValid[i] && allowNew && $urandom_range(3) == 0) newCommand(i);
            reqWdata[i] = $urandom;
        end
        if (phase == P_CMD && $urandom_range(11) == 0) reqValid[winner] = 1'b0;
        mi_ready = 1'($urandom_range(1));
        mi_rdata = $urandom;
        if (phase == P_DATA) begin
            beat     = ($urandom_range(3) != 0);
            mi_rstb  = beat && busRw;
            mi_rlast = beat && busRw && (beatsLeft == 1);
            mi_wack  = beat && !busRw;
            mi_wlast = beat && !busRw && (beatsLeft == 1);
        end else begin
            mi_rstb  = 1'($urandom_range(1));
            mi_rlast = 1'($urandom_range(1));
            mi_wack  = 1'($urandom_range(1));
            mi_wlast = 1'($urandom_range(1));
        end
        driveBus();
        #1;
        expReady = '0; expRstb = '0; expRlast = '0; expWack = '0; expWlast = '0;
        if (phase == P_CMD) expReady[winner] = mi_ready;
        if (phase == P_DATA && busRw) begin
            expRstb[winner]  = mi_rstb;
            expRlast[winner] = mi_rlast;
        end
        if (phase == P_DATA && !busRw) begin
            expWack[winner]  = mi_wack;
            expWlast[winner] = mi_wlast;
        end
        checkOutput("u_rdata", u_rdata, mi_rdata);
        checkOutput("mi_valid", 32'(mi_valid), 32'(phase == P_CMD && reqValid[winner]));
        checkOutput("u_ready", 32'(u_ready), 32'(expReady));
        checkOutput("u_rstb", 32'(u_rstb), 32'(expRstb));
        checkOutput("u_rlast", 32'(u_rlast), 32'(expRlast));
        checkOutput("u_wack", 32'(u_wack), 32'(expWack));
        checkOutput("u_wlast", 32'(u_wlast), 32'(expWlast));
        if (phase == P_CMD && reqValid[winner]) begin
            checkOutput("mi_addr", 32'(mi_addr), 32'(reqAddr[winner]));
            checkOutput("mi_len", 32'(mi_len), 32'(reqLen[winner]));
            checkOutput("mi_rw", 32'(mi_rw), 32'(reqRw[winner]));
        end
        if (phase == P_DATA && !busRw) checkOutput("mi_wdata", mi_wdata, reqWdata[winner]);
        case (phase)
            P_FREE: begin
                w = rrWinner();
                if (w >= 0) begin
                    winner = w;
                    phase  = P_CMD;
                end
            end
            P_CMD: begin
                if (reqValid[winner] && mi_ready) begin
                    lastWin          = winner;
                    busRw            = reqRw[winner];
                    beatsLeft        = int'(reqLen[winner]) + 1;
                    reqValid[winner] = 1'b0;
                    grantLog.push_back(winner);
                    phase            = P_DATA;
                end else if (!reqValid[winner]) begin
                    phase = P_FREE;
                end
            end
            default: begin
                if (beat) begin
                    beatsLeft--;
                    if (beatsLeft == 0) begin
                        phase = P_FREE;
                        txnDone++;
                    end
                end
            end
        endcase
        @(negedge clk);
    endtask

    // Asynchronous reset with stray controller strobes held high throughout.
    task automatic applyReset(input bit loadBoth);
        rst      = 1'b1;
        mi_ready = 1'b1;
        mi_rstb  = 1'b1;
        mi_rlast = 1'b1;
        mi_wack  = 1'b1;
        mi_wlast = 1'b1;
        if (loadBoth) begin
            for (int i = 0; i < N_REQ; i++) newCommand(i);
        end
        driveBus();
        #1;
        checkOutput("rst_mi_valid", 32'(mi_valid), 32'd0);
        checkOutput("rst_u_ready", 32'(u_ready), 32'd0);
        checkOutput("rst_u_rstb", 32'(u_rstb), 32'd0);
        checkOutput("rst_u_rlast", 32'(u_rlast), 32'd0);
        checkOutput("rst_u_wack", 32'(u_wack), 32'd0);
        checkOutput("rst_u_wlast", 32'(u_wlast), 32'd0);
        @(negedge clk);
        rst     = 1'b0;
        phase   = P_FREE;
        lastWin = N_REQ - 1;
    endtask

    task automatic runTxns(input int target, input int budget);
        int start;
        int cyc;
        start = txnDone;
        cyc   = 0;
        while ((txnDone - start) < target && cyc < budget) begin
            applyStimulus(1'b1);
            cyc++;
        end
        checkOutput("txn_budget", 32'((txnDone - start) >= target), 32'd1);
    endtask

    initial begin
        int mark;
        int cyc;
        logic [N_REQ-1:0] expStb;
        rst = 1'b1;
        u_addr = '0; u_len = '0; u_rw = '0; u_valid = '0; u_wdata = '0;
        mi_ready = 1'b0; mi_wack = 1'b0; mi_wlast = 1'b0; mi_rdata = '0;
        mi_rstb = 1'b0; mi_rlast = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            reqValid[i] = 1'b0; reqAddr[i] = '0; reqLen[i] = '0;
            reqRw[i] = 1'b0; reqWdata[i] = '0;
        end
        phase = P_FREE; winner = 0; lastWin = N_REQ - 1; beatsLeft = 0;
        busRw = 1'b0; txnDone = 0;

        @(negedge clk);
        applyReset(1'b0);

        runTxns(40, 2000);

        cyc = 0;
        while (phase != P_DATA && cyc < 200) begin
            applyStimulus(1'b1);
            cyc++;
        end
        checkOutput("reach_data", 32'(phase == P_DATA), 32'd1);
        if (phase == P_DATA) begin
            mi_rstb  = busRw;
            mi_wack  = !busRw;
            mi_rlast = 1'b0;
            mi_wlast = 1'b0;
            #1;
            expStb = '0;
            expStb[winner] = 1'b1;
            checkOutput("pre_rst_stb", 32'(busRw ? u_rstb : u_wack), 32'(expStb));
        end
        mark = grantLog.size();
        applyReset(1'b1);
        runTxns(1, 200);
        if (grantLog.size() > mark) checkOutput("first_after_rst", 32'(grantLog[mark]), 32'd0);
        else checkOutput("first_after_rst_seen", 32'd0, 32'd1);

        runTxns(40, 2000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
